// File: rtl/shift_rows_unit.sv
// Buffered forward/inverse AES ShiftRows stage with a DEPTH-entry output FIFO.
// Optional accepted-block counter port blk_count is enabled by SHIFT_ROWS_COUNT_EN.
module shift_rows_unit #(
   parameter int unsigned NB    = 4,
   parameter int unsigned DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_inverse,
   input  logic [0:32*NB-1]  in_state,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [0:32*NB-1]  out_state,
   output logic              out_inverse
`ifdef SHIFT_ROWS_COUNT_EN
   ,
   output logic [31:0]       blk_count
`endif
);

   localparam int unsigned W  = 32 * NB;
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [0:W-1]  perm;
   logic [0:W-1]  mem_state [DEPTH];
   logic          mem_inv   [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          accept;
   logic          pop;

   // Row r rotates by s_r columns; 256-bit states use the {0,1,3,4} offsets.
   for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int unsigned SH = (NB == 8 && r >= 2) ? r + 1 : r;
      for (genvar c = 0; c < NB; c++) begin : g_col
         localparam int unsigned DST = (r * NB + c) * 8;
         localparam int unsigned FSRC = (r * NB + (c + SH) % NB) * 8;
         localparam int unsigned ISRC = (r * NB + (c + NB - SH) % NB) * 8;
         assign perm[DST +: 8] = in_inverse ? in_state[ISRC +: 8] : in_state[FSRC +: 8];
      end
   end

   assign in_ready    = (count != CW'(DEPTH));
   assign out_valid   = (count != CW'(0));
   assign accept      = in_valid && in_ready;
   assign pop         = out_valid && out_ready;
   assign out_state   = mem_state[rd_ptr];
   assign out_inverse = mem_inv[rd_ptr];

   // Pointer and occupancy tracking; a simultaneous accept and pop leaves count unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + PW'(1);
         if (pop)    rd_ptr <= rd_ptr + PW'(1);
         case ({accept, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (accept && !rst) begin
         mem_state[wr_ptr] <= perm;
         mem_inv[wr_ptr]   <= in_inverse;
      end
   end

`ifdef SHIFT_ROWS_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst)         blk_count <= '0;
      else if (accept) blk_count <= blk_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_shift_rows_unit.sv
// Directed bench for shift_rows_unit: NB=4 and NB=8 instances, DEPTH=2.
module tb_shift_rows_unit;

   localparam logic [127:0] SEQ4 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
   localparam logic [127:0] FWD4 = 128'h00010203_05060704_0a0b0809_0f0c0d0e;
   localparam logic [127:0] INV4 = 128'h00010203_07040506_0a0b0809_0d0e0f0c;
   localparam logic [255:0] SEQ8 = 256'h0001020304050607_08090a0b0c0d0e0f_1011121314151617_18191a1b1c1d1e1f;
   localparam logic [255:0] FWD8 = 256'h0001020304050607_090a0b0c0d0e0f08_1314151617101112_1c1d1e1f18191a1b;
   localparam logic [255:0] INV8 = 256'h0001020304050607_0f08090a0b0c0d0e_1516171011121314_1c1d1e1f18191a1b;

   logic         clk = 1'b0;
   logic         rst;
   logic         v4, rdy4, inv4, ov4, or4, oinv4;
   logic [0:127] st4, ost4;
   logic         v8, rdy8, inv8, ov8, or8, oinv8;
   logic [0:255] st8, ost8;
`ifdef SHIFT_ROWS_COUNT_EN
   logic [31:0]  cnt4, cnt8;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   shift_rows_unit #(.NB(4), .DEPTH(2)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in_inverse(inv4),
      .in_state(st4), .out_valid(ov4), .out_ready(or4), .out_state(ost4),
      .out_inverse(oinv4)
`ifdef SHIFT_ROWS_COUNT_EN
      , .blk_count(cnt4)
`endif
   );

   shift_rows_unit #(.NB(8), .DEPTH(2)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_inverse(inv8),
      .in_state(st8), .out_valid(ov8), .out_ready(or8), .out_state(ost8),
      .out_inverse(oinv8)
`ifdef SHIFT_ROWS_COUNT_EN
      , .blk_count(cnt8)
`endif
   );

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive4(input logic v, input logic inv, input logic [127:0] st);
      v4   = v;
      inv4 = inv;
      st4  = st;
   endtask

   initial begin
      rst = 1'b1;
      drive4(1'b0, 1'b0, '0);
      or4 = 1'b0;
      v8 = 1'b0; inv8 = 1'b0; st8 = '0; or8 = 1'b0;
      tick(); tick();
      rst = 1'b0;
      check("rst_out_valid", 256'(ov4), 256'd0);
      check("rst_in_ready", 256'(rdy4), 256'd1);
`ifdef SHIFT_ROWS_COUNT_EN
      check("rst_blk_count", 256'(cnt4), 256'd0);
`endif

      // Forward and inverse single blocks, then inverse result fed back forward
      or4 = 1'b1;
      drive4(1'b1, 1'b0, SEQ4);
      tick();
      drive4(1'b0, 1'b0, '0);
      check("fwd4_valid", 256'(ov4), 256'd1);
      check("fwd4_state", 256'(ost4), 256'(FWD4));
      check("fwd4_mode", 256'(oinv4), 256'd0);
      tick();
      check("fwd4_popped", 256'(ov4), 256'd0);
      drive4(1'b1, 1'b1, SEQ4);
      tick();
      check("inv4_state", 256'(ost4), 256'(INV4));
      check("inv4_mode", 256'(oinv4), 256'd1);
      drive4(1'b1, 1'b0, INV4);
      tick();
      drive4(1'b0, 1'b0, '0);
      check("roundtrip4", 256'(ost4), 256'(SEQ4));
      tick();

      // Back-pressure: A,B fill the FIFO, C waits until space frees
      or4 = 1'b0;
      drive4(1'b1, 1'b0, SEQ4);
      tick();
      check("bp_ready_after_a", 256'(rdy4), 256'd1);
      drive4(1'b1, 1'b1, SEQ4);
      tick();
      check("bp_full_ready", 256'(rdy4), 256'd0);
      drive4(1'b1, 1'b1, FWD4);
      tick();
      check("bp_c_held_ready", 256'(rdy4), 256'd0);
      check("bp_head_a", 256'(ost4), 256'(FWD4));
      or4 = 1'b1;
      tick();
      check("bp_head_b", 256'(ost4), 256'(INV4));
      check("bp_ready_after_pop", 256'(rdy4), 256'd1);
      tick();
      drive4(1'b0, 1'b0, '0);
      check("bp_head_c", 256'(ost4), 256'(SEQ4));
      check("bp_head_c_mode", 256'(oinv4), 256'd1);
      tick();
      check("bp_drained", 256'(ov4), 256'd0);
`ifdef SHIFT_ROWS_COUNT_EN
      check("bp_blk_count", 256'(cnt4), 256'd6);
`endif

      rst = 1'b1;
      tick();
      rst = 1'b0;

      // Alternating modes back-to-back, one result per cycle
      for (int i = 0; i < 8; i++) begin
         drive4(1'b1, 1'(i % 2), SEQ4);
         tick();
         check("alt_ready", 256'(rdy4), 256'd1);
         check("alt_valid", 256'(ov4), 256'd1);
         check("alt_state", 256'(ost4), (i % 2 == 1) ? 256'(INV4) : 256'(FWD4));
         check("alt_mode", 256'(oinv4), 256'(i % 2));
      end
      drive4(1'b0, 1'b0, '0);
      tick();
      check("alt_drained", 256'(ov4), 256'd0);
`ifdef SHIFT_ROWS_COUNT_EN
      check("alt_blk_count", 256'(cnt4), 256'd8);
`endif

      // Reset with two blocks buffered discards them
      or4 = 1'b0;
      drive4(1'b1, 1'b0, SEQ4);
      tick(); tick();
      drive4(1'b0, 1'b0, '0);
      check("pre_rst_full", 256'(rdy4), 256'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_valid", 256'(ov4), 256'd0);
      check("mid_rst_ready", 256'(rdy4), 256'd1);
`ifdef SHIFT_ROWS_COUNT_EN
      check("mid_rst_blk_count", 256'(cnt4), 256'd0);
`endif
      drive4(1'b1, 1'b1, SEQ4);
      tick();
      drive4(1'b0, 1'b0, '0);
      or4 = 1'b1;
      check("post_rst_valid", 256'(ov4), 256'd1);
      check("post_rst_state", 256'(ost4), 256'(INV4));
      tick();
      check("post_rst_alone", 256'(ov4), 256'd0);

      // NB=8 forward and inverse
      or8 = 1'b1;
      v8 = 1'b1; inv8 = 1'b0; st8 = SEQ8;
      tick();
      check("fwd8_state", 256'(ost8), FWD8);
      check("fwd8_valid", 256'(ov8), 256'd1);
      inv8 = 1'b1;
      tick();
      v8 = 1'b0;
      check("inv8_state", 256'(ost8), INV8);
      check("inv8_mode", 256'(oinv8), 256'd1);
      tick();
      check("nb8_drained", 256'(ov8), 256'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/shift_rows_unit.md
# shift_rows_unit

Parametrised, buffered ShiftRows engine for the AES/Rijndael datapath. It applies the forward or inverse ShiftRows permutation, selected per block, to a state of NB columns (4, 6 or 8). Results are held in a DEPTH-entry output FIFO behind a valid/ready handshake. It sits between the SubBytes/InvSubBytes stage and the MixColumns/AddRoundKey stage and absorbs downstream stalls.

## Interface
Parameters:
- NB, default 4: state columns; legal values 4, 6, 8. Block width W = 32*NB.
- DEPTH, default 2: output FIFO entries; power of two, 2..16.

Ports:
- clk  input  1  sole clock; everything is clocked on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  an input block is offered.
- in_ready  output  1  the unit accepts a block this cycle.
- in_inverse  input  1  0 = forward ShiftRows, 1 = inverse; sampled with the block.
- in_state  input  [0:W-1]  input state, row-major.
- out_valid  output  1  the FIFO head is valid.
- out_ready  input  1  downstream consumes the head.
- out_state  output  [0:W-1]  permuted state at the FIFO head.
- out_inverse  output  1  mode bit that travelled with the head block.
- blk_count  output  32  accepted-block counter; present only with SHIFT_ROWS_COUNT_EN.

## Operation
- Byte layout: byte (r,c), r in 0..3 and c in 0..NB-1, occupies bits [(r*NB+c)*8 : (r*NB+c)*8+7]. Bit 0 is the MSB.
- Row shift s_r:
  - NB=4 or NB=6: s = {0,1,2,3}.
  - NB=8: s = {0,1,3,4}.
- Forward: out(r,c) = in(r,(c+s_r) mod NB).
- Inverse: out(r,c) = in(r,(c−s_r+NB) mod NB). Column indices wrap modulo NB, with no sign issues.
- The permutation is pure wiring, computed on in_state. The permuted block and in_inverse are written into the FIFO on acceptance.
- Accept occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- FIFO state:
  - wr_ptr and rd_ptr are log2(DEPTH) bits wide and wrap naturally.
  - count is log2(DEPTH)+1 bits wide.
  - in_ready = (count != DEPTH).
  - out_valid = (count != 0).
  - out_state and out_inverse come from mem[rd_ptr].
- Simultaneous accept and pop: both pointers advance and count is unchanged. This is legal at any count where in_ready=1.
- Full (count==DEPTH): in_ready=0, even if out_ready=1 in the same cycle. There is no full pass-through.
- Empty (count==0): out_valid=0 and out_state is don't-care. There is no bypass, so a block is never visible in its accept cycle.
- The mode may change on every block. No drain is needed between forward and inverse blocks.
- Once out_valid=1, the head and out_valid hold until popped.
- in_state and in_inverse need only be stable while in_valid=1 in the accept cycle.

## Timing
- Reset values: wr_ptr=0, rd_ptr=0, count=0, out_valid=0, in_ready=1, blk_count=0. FIFO memory is not reset.
- Reset mid-operation: all buffered blocks are discarded. Accepts and pops are ignored in the reset cycle. The first accept after reset can occur in the cycle after rst falls.
- Latency: a block accepted in cycle t appears at the head (if the FIFO was empty) with out_valid=1 in cycle t+1.
- Throughput is one block per cycle when out_ready=1 continuously.
- in_ready depends only on registered count, with no combinational path from out_ready. out_valid is likewise registered-derived.

## Configuration
- SHIFT_ROWS_COUNT_EN defined:
  - blk_count is added.
  - It increments by 1 on each accept and wraps 0xFFFFFFFF→0.
  - It is cleared by rst.
- SHIFT_ROWS_COUNT_EN undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- NB=4, forward, in_state=00 01 … 0f, out_ready=1 → next cycle out_state = 00 01 02 03 05 06 07 04 0a 0b 08 09 0f 0c 0d 0e and out_inverse=0.
- NB=4, inverse, same input → out_state = 00 01 02 03 07 04 05 06 0a 0b 08 09 0d 0e 0f 0c. Feeding that output back through forward mode returns 00..0f.
- NB=8, forward, in_state=00..1f → row 2 out = 13 14 15 16 17 10 11 12 and row 3 out = 1c 1d 1e 1f 18 19 1a 1b.
- DEPTH=2, out_ready=0, three consecutive in_valid blocks A,B,C → A and B accepted, in_ready=0 after the second accept, C held. Raising out_ready → A then B then C out, in order, with no loss or duplication.
- Alternating in_inverse 0/1 over 8 back-to-back blocks with out_ready=1 → one output per cycle, each matching its own mode. With SHIFT_ROWS_COUNT_EN, blk_count=8.
- 2 blocks buffered, assert rst for 1 cycle → out_valid=0, in_ready=1, blk_count=0. The next accept appears alone at the head one cycle later.
